// File: rtl/output_collector_pkg.sv
// Shared types and address helper for the output collector.
package output_collector_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN,
    DONE
  } state_t;

  // Channel-major linear address: (ch*H + y)*W + x.
  function automatic longint unsigned chw_addr(
    input longint unsigned x,
    input longint unsigned y,
    input longint unsigned ch,
    input longint unsigned w,
    input longint unsigned h
  );
    return (ch * h + y) * w + x;
  endfunction

endpackage

// File: rtl/collector_fifo.sv
// Synchronous FIFO holding {address, data} entries; head is read straight from storage.
module collector_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             last
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] used;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (used == CNT_W'(DEPTH));
  assign empty = (used == '0);
  assign last  = (used == CNT_W'(1));

endmodule

// File: rtl/output_collector.sv
// Collects accelerator output samples, buffers them and writes them to memory at CHW addresses.
// Optional macro OUTPUT_COLLECTOR_RELU_EN clamps negative samples to zero before buffering.
module output_collector
  import output_collector_pkg::*;
#(
  parameter int unsigned IO_DATA_WIDTH      = 16,
  parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
  parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
  parameter int unsigned OUTPUT_NB_CHANNELS = 64,
  parameter int unsigned FIFO_DEPTH         = 4,
  localparam int unsigned TOTAL  = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS,
  localparam int unsigned ADDR_W = $clog2(TOTAL)
) (
  input  logic                                  clk,
  input  logic                                  arst_n_in,
  input  logic                                  start,
  input  logic [IO_DATA_WIDTH-1:0]              out_data,
  input  logic                                  output_valid,
  input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
  input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
  input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch,
  output logic                                  mem_write_en,
  output logic [ADDR_W-1:0]                     mem_write_addr,
  output logic [IO_DATA_WIDTH-1:0]              mem_din,
  input  logic                                  mem_write_ready,
  output logic [ADDR_W:0]                       count,
  output logic                                  done,
  output logic                                  overflow,
  output logic                                  coord_err
);
  localparam int unsigned ENTRY_W = ADDR_W + IO_DATA_WIDTH;

  state_t                   state, state_next;
  logic                     in_range;
  logic [IO_DATA_WIDTH-1:0] data_in;
  logic [ADDR_W-1:0]        addr_in;
  logic                     push, pop, full, empty, last;
  logic [ENTRY_W-1:0]       head;

  assign in_range = (32'(output_x)  < FEATURE_MAP_WIDTH)  &&
                    (32'(output_y)  < FEATURE_MAP_HEIGHT) &&
                    (32'(output_ch) < OUTPUT_NB_CHANNELS);

  assign addr_in = ADDR_W'(chw_addr(64'(output_x), 64'(output_y), 64'(output_ch),
                                    64'(FEATURE_MAP_WIDTH), 64'(FEATURE_MAP_HEIGHT)));

`ifdef OUTPUT_COLLECTOR_RELU_EN
  assign data_in = out_data[IO_DATA_WIDTH-1] ? '0 : out_data;
`else
  assign data_in = out_data;
`endif

  assign pop  = !empty && mem_write_ready;
  // A full FIFO still accepts when its head leaves in the same cycle; start wins over everything.
  assign push = !start && (state == COLLECT) && output_valid && in_range && (!full || pop);

  collector_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (arst_n_in),
    .flush (start),
    .push  (push),
    .pop   (pop),
    .din   ({addr_in, data_in}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .last  (last)
  );

  assign mem_write_en   = !empty;
  assign mem_write_addr = head[ENTRY_W-1:IO_DATA_WIDTH];
  assign mem_din        = head[IO_DATA_WIDTH-1:0];
  assign done           = (state == DONE);

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = COLLECT;
    end else begin
      case (state)
        COLLECT: if (push && count == (ADDR_W+1)'(TOTAL - 1)) state_next = DRAIN;
        // Leave as soon as the final entry pops so done shows the following cycle.
        DRAIN:   if (empty || (last && pop)) state_next = DONE;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      count     <= '0;
      overflow  <= 1'b0;
      coord_err <= 1'b0;
    end else if (start) begin
      count     <= '0;
      overflow  <= 1'b0;
      coord_err <= 1'b0;
    end else begin
      if (push && count != (ADDR_W+1)'(TOTAL)) begin
        count <= count + 1'b1;
      end
      if (output_valid && ((state == DRAIN) ||
                           ((state == COLLECT) && in_range && full && !pop))) begin
        overflow <= 1'b1;
      end
      if (output_valid && (state == COLLECT) && !in_range) begin
        coord_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_output_collector.sv
// Scoreboard bench for output_collector (W=4,H=2,C=2) plus a W=4,H=3,C=2 instance for range checks.
module tb_output_collector;
  localparam int DW = 16;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          arst_n_in = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] out_data = '0;
  logic          output_valid = 1'b0;
  logic [1:0]    output_x = '0;
  logic [0:0]    output_y = '0;
  logic [0:0]    output_ch = '0;
  logic          mem_write_en;
  logic [AW-1:0] mem_write_addr;
  logic [DW-1:0] mem_din;
  logic          mem_write_ready = 1'b1;
  logic [AW:0]   count;
  logic          done, overflow, coord_err;

  logic          start2 = 1'b0;
  logic          valid2 = 1'b0;
  logic [1:0]    x2 = '0;
  logic [1:0]    y2 = '0;
  logic [0:0]    ch2 = '0;
  logic [DW-1:0] data2 = '0;
  logic          en2;
  logic [4:0]    addr2;
  logic [DW-1:0] din2;
  logic [5:0]    count2;
  logic          done2, overflow2, coord_err2;

  int n_checks = 0;
  int n_fail   = 0;
  int n_writes = 0;
  logic [AW+DW-1:0] sb [$];

  always #5 clk = ~clk;

  output_collector #(
    .IO_DATA_WIDTH      (DW),
    .FEATURE_MAP_WIDTH  (W),
    .FEATURE_MAP_HEIGHT (H),
    .OUTPUT_NB_CHANNELS (2),
    .FIFO_DEPTH         (4)
  ) dut (
    .clk             (clk),
    .arst_n_in       (arst_n_in),
    .start           (start),
    .out_data        (out_data),
    .output_valid    (output_valid),
    .output_x        (output_x),
    .output_y        (output_y),
    .output_ch       (output_ch),
    .mem_write_en    (mem_write_en),
    .mem_write_addr  (mem_write_addr),
    .mem_din         (mem_din),
    .mem_write_ready (mem_write_ready),
    .count           (count),
    .done            (done),
    .overflow        (overflow),
    .coord_err       (coord_err)
  );

  output_collector #(
    .IO_DATA_WIDTH      (DW),
    .FEATURE_MAP_WIDTH  (4),
    .FEATURE_MAP_HEIGHT (3),
    .OUTPUT_NB_CHANNELS (2),
    .FIFO_DEPTH         (4)
  ) dut_odd (
    .clk             (clk),
    .arst_n_in       (arst_n_in),
    .start           (start2),
    .out_data        (data2),
    .output_valid    (valid2),
    .output_x        (x2),
    .output_y        (y2),
    .output_ch       (ch2),
    .mem_write_en    (en2),
    .mem_write_addr  (addr2),
    .mem_din         (din2),
    .mem_write_ready (1'b1),
    .count           (count2),
    .done            (done2),
    .overflow        (overflow2),
    .coord_err       (coord_err2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [DW-1:0] d);
`ifdef OUTPUT_COLLECTOR_RELU_EN
    return d[DW-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  function automatic logic [AW-1:0] exp_addr(input int x, input int y, input int ch);
    return AW'((ch * H + y) * W + x);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int x, input int y, input int ch, input logic [DW-1:0] d, input bit store);
    output_x     = 2'(x);
    output_y     = 1'(y);
    output_ch    = 1'(ch);
    out_data     = d;
    output_valid = 1'b1;
    if (store) sb.push_back({exp_addr(x, y, ch), exp_data(d)});
    tick();
    output_valid = 1'b0;
  endtask

  task automatic sweep();
    for (int ch = 0; ch < 2; ch++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) begin
          int i;
          i = (ch * H + y) * W + x;
          send(x, y, ch, (i == 5) ? 16'hFFFB : 16'(i * 1234 - 3000), 1'b1);
        end
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while (mem_write_en && i < 40) begin
      tick();
      i++;
    end
    check("drain_timeout", mem_write_en, 0);
  endtask

  always @(negedge clk) begin
    if (mem_write_en && mem_write_ready) begin
      logic [AW+DW-1:0] e;
      n_writes++;
      if (sb.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        e = sb.pop_front();
        check("wr_addr", mem_write_addr, e[AW+DW-1:DW]);
        check("wr_data", mem_din, e[DW-1:0]);
      end
    end
  end

  initial begin
    int w0;
    #1;
    check("rst_en", mem_write_en, 0);
    check("rst_addr", mem_write_addr, 0);
    check("rst_din", mem_din, 0);
    check("rst_count", count, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_coord_err", coord_err, 0);
    tick();
    arst_n_in = 1'b1;
    tick();

    // Range check on the H=3 instance: y=3 is representable but illegal.
    start2 = 1'b1; tick(); start2 = 1'b0;
    x2 = 2'd1; y2 = 2'd3; ch2 = 1'b1; data2 = 16'd9; valid2 = 1'b1;
    tick();
    valid2 = 1'b0;
    check("oor_coord_err", coord_err2, 1);
    check("oor_count", count2, 0);
    check("oor_no_write", en2, 0);
    x2 = 2'd1; y2 = 2'd2; ch2 = 1'b1; data2 = 16'd7; valid2 = 1'b1;
    tick();
    valid2 = 1'b0;
    check("odd_count", count2, 1);
    check("odd_en", en2, 1);
    check("odd_addr", addr2, 21);
    check("odd_din", din2, 7);

    // Full layer sweep with ready held high.
    mem_write_ready = 1'b1;
    pulse_start();
    w0 = n_writes;
    sweep();
    check("lat_en", mem_write_en, 1);
    check("sweep_count", count, 16);
    check("sweep_done_early", done, 0);
    tick();
    check("sweep_done", done, 1);
    check("sweep_en_off", mem_write_en, 0);
    check("sweep_writes", n_writes - w0, 16);
    check("sweep_sb_empty", sb.size(), 0);
    send(0, 0, 0, 16'h1234, 1'b0);
    tick();
    check("done_ignore_count", count, 16);
    check("done_ignore_ovf", overflow, 0);
    check("done_held", done, 1);

    // Six samples into a stalled FIFO.
    mem_write_ready = 1'b0;
    pulse_start();
    check("restart_done", done, 0);
    check("restart_count", count, 0);
    w0 = n_writes;
    for (int k = 0; k < 6; k++) send(k % 4, k / 4, 0, 16'(100 + k), k < 4);
    check("ovf_flag", overflow, 1);
    check("ovf_count", count, 4);
    check("ovf_en", mem_write_en, 1);
    mem_write_ready = 1'b1;
    wait_drain();
    check("ovf_writes", n_writes - w0, 4);

    // Push and pop together on a full FIFO.
    mem_write_ready = 1'b0;
    pulse_start();
    check("flags_cleared", overflow, 0);
    w0 = n_writes;
    for (int k = 0; k < 4; k++) send(k, 1, 1, 16'(200 + k), 1'b1);
    check("full_no_ovf", overflow, 0);
    mem_write_ready = 1'b1;
    send(0, 0, 1, 16'd300, 1'b1);
    mem_write_ready = 1'b0;
    check("pushpop_ovf", overflow, 0);
    check("pushpop_count", count, 5);
    send(1, 0, 1, 16'd301, 1'b0);
    check("still_full_ovf", overflow, 1);
    check("still_full_count", count, 5);
    mem_write_ready = 1'b1;
    wait_drain();
    check("pushpop_writes", n_writes - w0, 5);

    // Asynchronous reset part-way through a layer.
    mem_write_ready = 1'b0;
    pulse_start();
    for (int k = 0; k < 5; k++) send(k % 4, 0, 0, 16'(400 + k), 1'b0);
    #2 arst_n_in = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_en", mem_write_en, 0);
    check("arst_ovf", overflow, 0);
    check("arst_done", done, 0);
    tick();
    arst_n_in = 1'b1;
    mem_write_ready = 1'b1;
    tick();
    pulse_start();
    w0 = n_writes;
    sweep();
    tick();
    check("fresh_done", done, 1);
    check("fresh_count", count, 16);
    check("fresh_writes", n_writes - w0, 16);
    check("fresh_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
